pong_key_tracker: RTL and testbench



---
 rtl/pong_key_tracker.sv | 145 ++++++++++++++
 tb/tb_pong_key_tracker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_key_tracker.sv
// PS/2 set-2 scan-code decoder producing per-key control bits for Pong.
// Optional `PREFIX_TIMEOUT_EN abandons a stalled E0/F0 prefix after PREFIX_TIMEOUT idle cycles.
module pong_key_tracker #(
    parameter int PULSE_OR_HOLD  = 0,
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    output logic       up,
    output logic       down,
    output logic       w,
    output logic       s,
    output logic       space,
    output logic       enter
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_W     = 2;
    localparam int K_S     = 3;
    localparam int K_SPACE = 4;
    localparam int K_ENTER = 5;

    state_t     state_q, state_d;
    logic [5:0] held_q, held_d;
    logic [5:0] out_q, out_d;
    logic [5:0] make_ev, brk_ev;
    logic [5:0] base_key, ext_key;
    logic       timeout_hit;

    always_comb begin
        base_key = '0;
        ext_key  = '0;
        case (ps2_byte)
            8'h1D:   base_key[K_W]     = 1'b1;
            8'h1B:   base_key[K_S]     = 1'b1;
            8'h29:   base_key[K_SPACE] = 1'b1;
            8'h5A:   base_key[K_ENTER] = 1'b1;
            default: base_key          = '0;
        endcase
        case (ps2_byte)
            8'h75:   ext_key[K_UP]   = 1'b1;
            8'h72:   ext_key[K_DOWN] = 1'b1;
            default: ext_key         = '0;
        endcase
    end

`ifdef PREFIX_TIMEOUT_EN
    localparam int CW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d       = '0;
        timeout_hit = 1'b0;
        if (state_q != IDLE && !ps2_byte_valid) begin
            if (cnt_q == CW'(PREFIX_TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        make_ev = '0;
        brk_ev  = '0;
        if (ps2_byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (ps2_byte == 8'hE0)      state_d = EXT;
                    else if (ps2_byte == 8'hF0) state_d = BRK;
                    else                        make_ev = base_key;
                end
                EXT: begin
                    if (ps2_byte == 8'hF0)      state_d = EXT_BRK;
                    else if (ps2_byte == 8'hE0) state_d = EXT;
                    else begin
                        make_ev = ext_key;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    if (ps2_byte == 8'hF0) state_d = BRK;
                    else begin
                        brk_ev  = base_key;
                        state_d = IDLE;
                    end
                end
                EXT_BRK: begin
                    brk_ev  = ext_key;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
        end

        held_d = (held_q & ~brk_ev) | make_ev;
        // Pulse only on a make that finds the key released, so typematic repeats stay silent.
        out_d  = (PULSE_OR_HOLD != 0) ? (make_ev & ~held_q) : held_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            held_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            out_q   <= out_d;
        end
    end

    assign up    = out_q[K_UP];
    assign down  = out_q[K_DOWN];
    assign w     = out_q[K_W];
    assign s     = out_q[K_S];
    assign space = out_q[K_SPACE];
    assign enter = out_q[K_ENTER];

endmodule

// File: tb/tb_pong_key_tracker.sv
// Self-checking bench for pong_key_tracker: hold- and pulse-mode instances driven in parallel.
// Output vectors are {enter, space, s, w, down, up}; timeout cases depend on `PREFIX_TIMEOUT_EN.
module tb_pong_key_tracker;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;

    logic h_up, h_down, h_w, h_s, h_space, h_enter;
    logic p_up, p_down, p_w, p_s, p_space, p_enter;
    logic [5:0] hv, pv;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what keys are down, which pulses are due, pending prefix bytes seen.
    logic [5:0] m_held, m_pls;
    bit         m_ext, m_brk;
    int         m_idle;

    always #5 clk = ~clk;

    assign hv = {h_enter, h_space, h_s, h_w, h_down, h_up};
    assign pv = {p_enter, p_space, p_s, p_w, p_down, p_up};

    pong_key_tracker #(.PULSE_OR_HOLD(0), .PREFIX_TIMEOUT(TO)) u_hold (
        .clk(clk), .reset(reset), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
        .up(h_up), .down(h_down), .w(h_w), .s(h_s), .space(h_space), .enter(h_enter)
    );

    pong_key_tracker #(.PULSE_OR_HOLD(1), .PREFIX_TIMEOUT(TO)) u_pulse (
        .clk(clk), .reset(reset), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
        .up(p_up), .down(p_down), .w(p_w), .s(p_s), .space(p_space), .enter(p_enter)
    );

    function automatic int key_of(input logic [7:0] b, input bit extended);
        if (extended) begin
            if (b == 8'h75) return 0;
            if (b == 8'h72) return 1;
            return -1;
        end
        if (b == 8'h1D) return 2;
        if (b == 8'h1B) return 3;
        if (b == 8'h29) return 4;
        if (b == 8'h5A) return 5;
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic v, input logic [7:0] b);
        int k;
        m_pls = '0;
        if (rst) begin
            m_held = '0; m_ext = 0; m_brk = 0; m_idle = 0;
            return;
        end
        if (!v) begin
`ifdef PREFIX_TIMEOUT_EN
            if (m_ext || m_brk) begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_ext = 0; m_brk = 0; m_idle = 0;
                end
            end
`endif
            return;
        end
        m_idle = 0;
        k = key_of(b, m_ext);
        if (b == 8'hF0 && !(m_ext && m_brk)) begin
            m_brk = 1;
        end else if (b == 8'hE0 && !m_brk) begin
            m_ext = 1;
        end else begin
            if (k >= 0) begin
                if (m_brk) m_held[k] = 1'b0;
                else begin
                    if (!m_held[k]) m_pls[k] = 1'b1;
                    m_held[k] = 1'b1;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), then return at the next negedge.
    task automatic cycle(input logic rst, input logic v, input logic [7:0] b);
        reset = rst; ps2_byte_valid = v; ps2_byte = b;
        model_step(rst, v, b);
        @(negedge clk);
        reset = 1'b0; ps2_byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1, 0, 8'h00);
        cycle(1, 0, 8'h00);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL reset_state: got %b want %b", {hv, pv}, 12'h000);
        end
        cycle(1, 1, 8'h1D);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL reset_beats_valid: got %b want %b", {hv, pv}, 12'h000);
        end
    endtask

    task automatic test_hold_w();
        cycle(0, 1, 8'h1D);
        n_cmp++;
        if ({hv, pv} !== {6'b000100, 6'b000100}) begin
            n_bad++; $display("FAIL w_make: got %b want %b", {hv, pv}, {6'b000100, 6'b000100});
        end
        cycle(0, 0, 8'h00);
        n_cmp++;
        if ({hv, pv} !== {6'b000100, 6'b000000}) begin
            n_bad++; $display("FAIL w_held: got %b want %b", {hv, pv}, {6'b000100, 6'b000000});
        end
        cycle(0, 1, 8'hF0);
        n_cmp++;
        if (hv !== 6'b000100) begin
            n_bad++; $display("FAIL w_after_f0: got %b want %b", hv, 6'b000100);
        end
        cycle(0, 1, 8'h1D);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL w_break: got %b want %b", {hv, pv}, 12'h000);
        end
    endtask

    task automatic test_arrows();
        cycle(0, 1, 8'hE0);
        cycle(0, 1, 8'h75);
        n_cmp++;
        if ({hv, pv} !== {6'b000001, 6'b000001}) begin
            n_bad++; $display("FAIL up_make: got %b want %b", {hv, pv}, {6'b000001, 6'b000001});
        end
        cycle(0, 1, 8'h75);
        n_cmp++;
        if ({hv, pv} !== {6'b000001, 6'b000000}) begin
            n_bad++; $display("FAIL keypad8_ignored: got %b want %b", {hv, pv}, {6'b000001, 6'b000000});
        end
        cycle(0, 1, 8'hE0);
        cycle(0, 1, 8'h72);
        n_cmp++;
        if ({hv, pv} !== {6'b000011, 6'b000010}) begin
            n_bad++; $display("FAIL down_make: got %b want %b", {hv, pv}, {6'b000011, 6'b000010});
        end
        cycle(0, 1, 8'hE0);
        cycle(0, 1, 8'hF0);
        cycle(0, 1, 8'h75);
        n_cmp++;
        if ({hv, pv} !== {6'b000010, 6'b000000}) begin
            n_bad++; $display("FAIL up_break: got %b want %b", {hv, pv}, {6'b000010, 6'b000000});
        end
        cycle(0, 1, 8'hE0);
        cycle(0, 1, 8'hF0);
        cycle(0, 1, 8'h72);
        n_cmp++;
        if (hv !== 6'b000000) begin
            n_bad++; $display("FAIL down_break: got %b want %b", hv, 6'b000000);
        end
    endtask

    task automatic test_pulse_typematic();
        cycle(0, 1, 8'h29);
        n_cmp++;
        if ({hv, pv} !== {6'b010000, 6'b010000}) begin
            n_bad++; $display("FAIL space_first: got %b want %b", {hv, pv}, {6'b010000, 6'b010000});
        end
        cycle(0, 1, 8'h29);
        n_cmp++;
        if (pv !== 6'b000000) begin
            n_bad++; $display("FAIL space_repeat1: got %b want %b", pv, 6'b000000);
        end
        cycle(0, 1, 8'h29);
        n_cmp++;
        if ({hv, pv} !== {6'b010000, 6'b000000}) begin
            n_bad++; $display("FAIL space_repeat2: got %b want %b", {hv, pv}, {6'b010000, 6'b000000});
        end
        cycle(0, 1, 8'hF0);
        cycle(0, 1, 8'h29);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL space_break: got %b want %b", {hv, pv}, 12'h000);
        end
        cycle(0, 1, 8'h29);
        n_cmp++;
        if (pv !== 6'b010000) begin
            n_bad++; $display("FAIL space_repulse: got %b want %b", pv, 6'b010000);
        end
        cycle(0, 0, 8'h00);
        n_cmp++;
        if (pv !== 6'b000000) begin
            n_bad++; $display("FAIL space_pulse_width: got %b want %b", pv, 6'b000000);
        end
        cycle(0, 1, 8'hF0);
        cycle(0, 1, 8'h29);
    endtask

    task automatic test_keypad_enter();
        cycle(0, 1, 8'hE0);
        cycle(0, 1, 8'h5A);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL keypad_enter: got %b want %b", {hv, pv}, 12'h000);
        end
        cycle(0, 1, 8'h5A);
        n_cmp++;
        if ({hv, pv} !== {6'b100000, 6'b100000}) begin
            n_bad++; $display("FAIL main_enter: got %b want %b", {hv, pv}, {6'b100000, 6'b100000});
        end
        cycle(0, 1, 8'hF0);
        cycle(0, 1, 8'h5A);
    endtask

    task automatic test_reset_mid_sequence();
        cycle(0, 1, 8'h1B);
        cycle(0, 1, 8'hE0);
        cycle(0, 1, 8'hF0);
        cycle(1, 0, 8'h00);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL reset_mid_clear: got %b want %b", {hv, pv}, 12'h000);
        end
        cycle(0, 1, 8'h72);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL reset_mid_72: got %b want %b", {hv, pv}, 12'h000);
        end
        cycle(0, 1, 8'hE0);
        cycle(1, 0, 8'h00);
        cycle(0, 1, 8'h75);
        n_cmp++;
        if ({hv, pv} !== 12'h000) begin
            n_bad++; $display("FAIL reset_drops_e0: got %b want %b", {hv, pv}, 12'h000);
        end
    endtask

    task automatic test_prefix_timeout();
        int gaps[4] = '{10, 15, 16, 20};
        bit exp_up;
        foreach (gaps[i]) begin
            cycle(0, 1, 8'hE0);
            for (int j = 0; j < gaps[i]; j++) cycle(0, 0, 8'h00);
            cycle(0, 1, 8'h75);
`ifdef PREFIX_TIMEOUT_EN
            exp_up = (gaps[i] < TO);
`else
            exp_up = 1'b1;
`endif
            n_cmp++;
            if (h_up !== exp_up) begin
                n_bad++; $display("FAIL prefix_gap_%0d: got up=%b want %b", gaps[i], h_up, exp_up);
            end
            cycle(0, 1, 8'hE0);
            cycle(0, 1, 8'hF0);
            cycle(0, 1, 8'h75);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[8] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h75, 8'h72};
        logic [7:0] b;
        int unsigned sel;
        cycle(1, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            b = (sel < 8) ? pool[sel] : 8'($urandom());
            if ($urandom_range(0, 299) == 0) begin
                cycle(1, $urandom_range(0, 1) == 1, b);
            end else if ($urandom_range(0, 59) == 0) begin
                for (int j = 0; j < int'($urandom_range(14, 20)); j++) cycle(0, 0, 8'h00);
            end else begin
                cycle(0, $urandom_range(0, 2) != 0, b);
            end
            n_cmp++;
            if ({hv, pv} !== {m_held, m_pls}) begin
                n_bad++;
                $display("FAIL random_%0d: got hold=%b pulse=%b want hold=%b pulse=%b",
                         n, hv, pv, m_held, m_pls);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ps2_byte = 8'h00; ps2_byte_valid = 1'b0;
        m_held = '0; m_pls = '0; m_ext = 0; m_brk = 0; m_idle = 0;
        @(negedge clk);
        test_reset();
        test_hold_w();
        test_arrows();
        test_pulse_typematic();
        test_keypad_enter();
        test_reset_mid_sequence();
        test_prefix_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
